// File: rtl/decode_issue_if.sv
// Decode/issue handshake bundle: instruction in, decoded op out, writeback retire.
// master = upstream/execute/writeback side, slave = decode_issue itself.
interface decode_issue_if #(
    parameter int DATA_W = 32,
    parameter int SEL_W  = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [0:DATA_W-1] instr;          // bit 0 is the MSB
    logic              out_valid;
    logic              out_ready;
    logic [5:0]        opcode;
    logic [SEL_W-1:0]  select_write;
    logic [SEL_W-1:0]  select_read_A;
    logic [SEL_W-1:0]  select_read_B;
    logic [DATA_W-1:0] imm;
    logic              use_imm;
    logic              wb_valid;
    logic [SEL_W-1:0]  wb_sel;
    logic [31:0]       stall_count;

    modport master (
        output in_valid, instr, out_ready, wb_valid, wb_sel,
        input  in_ready, out_valid, opcode, select_write, select_read_A,
               select_read_B, imm, use_imm, stall_count
    );

    modport slave (
        input  in_valid, instr, out_ready, wb_valid, wb_sel,
        output in_ready, out_valid, opcode, select_write, select_read_A,
               select_read_B, imm, use_imm, stall_count
    );
endinterface

// File: rtl/decode_issue.sv
// Decode/issue stage: field extraction, pending-writeback scoreboard, RAW/WAW stall.
// Optional macro DECODE_PERF_EN adds a saturating hazard-stall cycle counter.
module decode_issue #(
    parameter int DATA_W = 32,
    parameter int SEL_W  = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    decode_issue_if.slave bus
);
    localparam int NREG = 2 ** SEL_W;

    typedef struct packed {
        logic [5:0]        opcode;
        logic [SEL_W-1:0]  sw;
        logic [SEL_W-1:0]  ra;
        logic [SEL_W-1:0]  rb;
        logic [DATA_W-1:0] imm;
        logic              use_imm;
    } op_t;

    logic [SEL_W-1:0] rd, rs1, rs2;
    logic             use_imm_d, writes_rd, hazard, issue, out_valid_q;
    logic [NREG-1:1]  pend_q;
    logic [NREG-1:0]  retire_mask, set_mask, eff_pend;
    op_t              op_d, op_q;

    assign rd        = bus.instr[6 +: SEL_W];
    assign rs1       = bus.instr[6 + SEL_W +: SEL_W];
    assign rs2       = bus.instr[6 + 2*SEL_W +: SEL_W];
    assign use_imm_d = bus.instr[1];
    assign writes_rd = !bus.instr[0] && (rd != '0);

    always_comb begin
        retire_mask = '0;
        if (bus.wb_valid && bus.wb_sel != '0) retire_mask[bus.wb_sel] = 1'b1;
        set_mask = '0;
        if (issue && writes_rd) set_mask[rd] = 1'b1;
    end

    // A writeback retiring this cycle already reaches the regfile, so it unblocks now.
    assign eff_pend = {pend_q & ~retire_mask[NREG-1:1], 1'b0};
    assign hazard   = eff_pend[rs1] | (!use_imm_d & eff_pend[rs2]) | (writes_rd & eff_pend[rd]);
    assign bus.in_ready = !hazard && (!out_valid_q || bus.out_ready);
    assign issue        = bus.in_valid && bus.in_ready;

    always_comb begin
        op_d         = '0;
        op_d.opcode  = bus.instr[0:5];
        op_d.sw      = writes_rd ? rd : '0;
        op_d.ra      = rs1;
        op_d.rb      = use_imm_d ? '0 : rs2;
        op_d.imm     = {{(DATA_W-16){bus.instr[16]}}, bus.instr[16:31]};
        op_d.use_imm = use_imm_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q      <= '0;
            out_valid_q <= 1'b0;
            op_q        <= '0;
        end else begin
            // set after clear: a same-cycle retire and re-issue of rd leaves it pending
            pend_q <= eff_pend[NREG-1:1] | set_mask[NREG-1:1];
            if (issue) begin
                out_valid_q <= 1'b1;
                op_q        <= op_d;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.out_valid     = out_valid_q;
    assign bus.opcode        = op_q.opcode;
    assign bus.select_write  = op_q.sw;
    assign bus.select_read_A = op_q.ra;
    assign bus.select_read_B = op_q.rb;
    assign bus.imm           = op_q.imm;
    assign bus.use_imm       = op_q.use_imm;

`ifdef DECODE_PERF_EN
    logic [31:0] stall_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_q <= '0;
        else if (bus.in_valid && hazard && stall_q != 32'hFFFF_FFFF)
            stall_q <= stall_q + 32'd1;
    end
    assign bus.stall_count = stall_q;
`else
    assign bus.stall_count = 32'h0;
`endif
endmodule
